als_spi_multi_reader: RTL and testbench

//   Parametrised SPI read master for ADC081S-class light sensors (PmodALS style) on a shared

---
 rtl/als_spi_multi_reader.sv | 172 +++++++++++++++++
 tb/tb_als_spi_multi_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/als_spi_multi_reader.sv
// ---------------------------------------------------------------------------
// als_spi_multi_reader
//   SPI read master for ADC081S-class light sensors sharing one SCLK/MISO
//   pair, with one active-low chip select per sensor. Each read clocks one
//   frame of FRAME bits, keeps the DW-bit data field that follows LEAD
//   discarded bits, and reports it with the channel it came from.
//
//   Handshake: ready=1 means the FSM is idle. A request is taken on a rising
//   Clock edge where ready=1 and either auto=1 (round-robin channel) or
//   fetch=1 with chan<NCH (chan sampled on that same edge). Nothing is
//   queued; fetch/chan/auto seen while busy are dropped. Completion is a
//   one-cycle arrived pulse in the cycle illum/illum_chan take their new
//   values, and ready is already 1 in that cycle.
//
// Ports
//   Clock       in   system clock, rising edge
//   Reset       in   synchronous, active-high
//   fetch       in   single-read request
//   chan        in   channel for fetch
//   auto        in   continuous round-robin polling
//   ready       out  idle, will accept a request
//   arrived     out  one-cycle completion pulse
//   illum       out  last data field received
//   illum_chan  out  channel of illum
//   SCLK        out  SPI clock, idles high
//   MISO        in   serial data from the selected sensor
//   CS          out  active-low chip selects, at most one low
//   fsm_state   out  current FSM state, for debug/checkers
// ---------------------------------------------------------------------------
module als_spi_multi_reader #(
    parameter  int NCH   = 4,
    parameter  int FRAME = 16,
    parameter  int DW    = 8,
    parameter  int LEAD  = 3,
    parameter  int DIV   = 4,
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            fetch,
    input  logic [CW-1:0]   chan,
    input  logic            auto,
    output logic            ready,
    output logic            arrived,
    output logic [DW-1:0]   illum,
    output logic [CW-1:0]   illum_chan,
    output logic            SCLK,
    input  logic            MISO,
    output logic [NCH-1:0]  CS,
    output logic [2:0]      fsm_state
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_QUIET = 3'd4;

    logic [2:0]     state;
    logic [DCW-1:0] cnt;      // Clock cycles spent in the current phase
    logic [BW-1:0]  bitn;     // frame bit index of the current SCLK period
    logic [CW-1:0]  ch;       // channel of the frame in progress
    logic [CW-1:0]  rr;       // next channel for auto polling
    logic [DW-1:0]  shreg;

    logic cnt_last;
    logic bit_last;
    logic rr_last;
    logic chan_ok;
    logic in_data;

    assign cnt_last = (cnt == DCW'(DIV - 1));
    assign bit_last = (bitn == BW'(FRAME - 1));
    assign rr_last  = (rr == CW'(NCH - 1));
    // chan is wide enough to name channels that do not exist when NCH is
    // not a power of two; those requests are dropped.
    assign chan_ok  = (int'(chan) < NCH);
    assign in_data  = (int'(bitn) >= LEAD) && (int'(bitn) < LEAD + DW);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bitn       <= '0;
            ch         <= '0;
            rr         <= '0;
            shreg      <= '0;
            illum      <= '0;
            illum_chan <= '0;
            arrived    <= 1'b0;
        end else begin
            arrived <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt  <= '0;
                    bitn <= '0;
                    if (auto) begin
                        ch    <= rr;
                        rr    <= rr_last ? '0 : rr + CW'(1);
                        state <= S_SETUP;
                    end else if (fetch && chan_ok) begin
                        ch    <= chan;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= S_LOW;
                    end else begin
                        cnt <= cnt + DCW'(1);
                    end
                end
                S_LOW: begin
                    // The edge leaving LOW is the SCLK rising edge, where the
                    // sensor's bit for this period is stable.
                    if (cnt_last) begin
                        cnt   <= '0;
                        state <= S_HIGH;
                        if (in_data) begin
                            shreg <= (shreg << 1) | DW'(MISO);
                        end
                    end else begin
                        cnt <= cnt + DCW'(1);
                    end
                end
                S_HIGH: begin
                    if (cnt_last) begin
                        cnt <= '0;
                        if (bit_last) begin
                            state <= S_QUIET;
                        end else begin
                            bitn  <= bitn + BW'(1);
                            state <= S_LOW;
                        end
                    end else begin
                        cnt <= cnt + DCW'(1);
                    end
                end
                S_QUIET: begin
                    if (cnt_last) begin
                        cnt        <= '0;
                        illum      <= shreg;
                        illum_chan <= ch;
                        arrived    <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt + DCW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // SPI pins are decoded straight from the state register, so a reset
    // parks them (CS all high, SCLK high) on the same edge it clears state.
    assign ready     = (state == S_IDLE) && !Reset;
    assign SCLK      = (state != S_LOW);
    assign fsm_state = state;

    always_comb begin
        CS = '1;
        if (state == S_SETUP || state == S_LOW || state == S_HIGH) begin
            CS = ~(NCH'(1) << ch);
        end
    end

endmodule

// File: tb/tb_als_spi_multi_reader.sv
module tb_als_spi_multi_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: default build, four sensors
    logic       fetch_a, auto_a, miso_a;
    logic [1:0] chan_a;
    logic       ready_a, arrived_a, sclk_a;
    logic [7:0] illum_a;
    logic [1:0] ichan_a;
    logic [3:0] cs_a;
    logic [2:0] st_a;

    // Instance B: DIV=1, NCH=1, LEAD=0, DW=16
    logic        fetch_b, auto_b, miso_b;
    logic [0:0]  chan_b;
    logic        ready_b, arrived_b, sclk_b;
    logic [15:0] illum_b;
    logic [0:0]  ichan_b;
    logic [0:0]  cs_b;
    logic [2:0]  st_b;

    als_spi_multi_reader dut_a (
        .Clock(clk), .Reset(rst), .fetch(fetch_a), .chan(chan_a), .auto(auto_a),
        .ready(ready_a), .arrived(arrived_a), .illum(illum_a), .illum_chan(ichan_a),
        .SCLK(sclk_a), .MISO(miso_a), .CS(cs_a), .fsm_state(st_a)
    );

    als_spi_multi_reader #(.NCH(1), .FRAME(16), .DW(16), .LEAD(0), .DIV(1)) dut_b (
        .Clock(clk), .Reset(rst), .fetch(fetch_b), .chan(chan_b), .auto(auto_b),
        .ready(ready_b), .arrived(arrived_b), .illum(illum_b), .illum_chan(ichan_b),
        .SCLK(sclk_b), .MISO(miso_b), .CS(cs_b), .fsm_state(st_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [9:0] exp_q[$];          // {channel, data} per expected arrival

    // ---------------- sensor models ----------------
    logic [15:0] sens_a [4];
    logic [15:0] word_b;
    int   rises_a = 0, frame_rises_a = 0, cs_viol = 0, rises_b = 0;
    logic prev_sclk_a = 1'b1, prev_sclk_b = 1'b1;
    logic [3:0] prev_cs_a = 4'hF;
    logic [3:0] cs_seen_a = 4'h0;

    function automatic int low_idx(input logic [3:0] c);
        low_idx = 0;
        for (int i = 0; i < 4; i++) if (!c[i]) low_idx = i;
    endfunction

    // The sensor presents bit n after the n-th SCLK rising edge of the frame
    // (i.e. it shifts on the falling side), MSB of the word first.
    always @(negedge clk) begin
        if (cs_a == 4'hF) begin
            if (prev_cs_a != 4'hF) frame_rises_a = rises_a;
            rises_a = 0;
            miso_a  = 1'b0;
        end else begin
            cs_seen_a = cs_seen_a | ~cs_a;
            if (!prev_sclk_a && sclk_a) rises_a++;
            miso_a = (rises_a < 16) ? sens_a[low_idx(cs_a)][15 - rises_a] : 1'b0;
        end
        if ($countones(~cs_a) > 1) cs_viol++;
        prev_sclk_a = sclk_a;
        prev_cs_a   = cs_a;
    end

    always @(negedge clk) begin
        if (cs_b[0]) begin
            rises_b = 0;
            miso_b  = 1'b0;
        end else begin
            if (!prev_sclk_b && sclk_b) rises_b++;
            miso_b = (rises_b < 16) ? word_b[15 - rises_b] : 1'b0;
        end
        prev_sclk_b = sclk_b;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] make_word(input logic [7:0] d);
        make_word = {3'($urandom_range(0, 7)), d, 5'($urandom_range(0, 31))};
    endfunction

    // Drive a one-cycle fetch; returns just after the accepting edge k.
    task automatic fetch_go_a(input logic [1:0] c, input logic [15:0] w, input logic [7:0] d);
        sens_a[c] = w;
        exp_q.push_back({c, d});
        cs_seen_a = 4'h0;
        @(negedge clk);
        fetch_a = 1'b1;
        chan_a  = c;
        @(posedge clk);
        #1;
        fetch_a = 1'b0;
        chan_a  = 2'($urandom_range(0, 3));
    endtask

    // Counts cycles after edge k (first sample is cycle k+1) until arrived.
    task automatic wait_arr_a(input int start, input int chn, output int lat,
                              output int cs_first, output int cs_last, output logic rdy1);
        int cyc;
        cyc = start; lat = -1; cs_first = -1; cs_last = -1; rdy1 = 1'bx;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) rdy1 = ready_a;
            if (chn >= 0 && !cs_a[chn]) begin
                if (cs_first < 0) cs_first = cyc;
                cs_last = cyc;
            end
        end while (!arrived_a && cyc < 400);
        if (arrived_a) lat = cyc;
    endtask

    task automatic score_a(input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s_unexpected: observed=arrival expected=none", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_chan"}, 32'(ichan_a), 32'(e[9:8]));
            check({tag, "_data"}, 32'(illum_a), 32'(e[7:0]));
        end
    endtask

    task automatic idle_watch_a(input int n, output int arr, output int csl, output int nrdy);
        arr = 0; csl = 0; nrdy = 0;
        repeat (n) begin
            @(negedge clk);
            if (arrived_a) arr++;
            if (cs_a != 4'hF) csl++;
            if (!ready_a) nrdy++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, f, l, arr, csl, nrdy, guard, cyc;
        logic rdy1;
        logic [7:0] t2_data [4];
        logic [7:0] d3 [4];
        logic [7:0] d4;

        t2_data[0] = 8'b10101010; t2_data[1] = 8'b01000101;
        t2_data[2] = 8'b01110010; t2_data[3] = 8'b11110011;

        rst = 1'b1;
        fetch_a = 1'b0; auto_a = 1'b0; chan_a = 2'd0;
        fetch_b = 1'b0; auto_b = 1'b0; chan_b = 1'b0;
        for (int i = 0; i < 4; i++) sens_a[i] = 16'h0;
        word_b = 16'h0;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_ready", 32'(ready_a), 0);
        check("rst_arrived", 32'(arrived_a), 0);
        check("rst_illum", 32'(illum_a), 0);
        check("rst_ichan", 32'(ichan_a), 0);
        check("rst_sclk", 32'(sclk_a), 1);
        check("rst_cs", 32'(cs_a), 32'hF);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", 32'(ready_a), 1);
        check("post_rst_ready_b", 32'(ready_b), 1);

        // 1: single read, latency and chip-select window
        fetch_go_a(2'd0, 16'b000_01000010_00000, 8'b01000010);
        wait_arr_a(0, 0, lat, f, l, rdy1);
        check("t1_latency", 32'(lat), 137);
        check("t1_ready_k1", 32'(rdy1), 0);
        check("t1_cs_first", 32'(f), 1);
        check("t1_cs_last", 32'(l), 132);
        check("t1_ready_at_arrival", 32'(ready_a), 1);
        score_a("t1");
        check("t1_sclk_rises", 32'(frame_rises_a), 16);
        @(negedge clk);
        check("t1_arrived_pulse", 32'(arrived_a), 0);

        // 2: one read per channel
        for (int c = 0; c < 4; c++) begin
            fetch_go_a(2'(c), make_word(t2_data[c]), t2_data[c]);
            wait_arr_a(0, c, lat, f, l, rdy1);
            check($sformatf("t2_ch%0d_latency", c), 32'(lat), 137);
            score_a($sformatf("t2_ch%0d", c));
            check($sformatf("t2_ch%0d_cs_mask", c), 32'(cs_seen_a), 32'(1 << c));
            check($sformatf("t2_ch%0d_rises", c), 32'(frame_rises_a), 16);
        end

        // 3: auto polling, fetch held high throughout is ignored
        for (int i = 0; i < 4; i++) begin
            d3[i] = 8'($urandom_range(0, 255));
            sens_a[i] = make_word(d3[i]);
        end
        for (int i = 0; i < 5; i++) exp_q.push_back({2'(i % 4), d3[i % 4]});
        @(negedge clk);
        auto_a = 1'b1; fetch_a = 1'b1; chan_a = 2'd2;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                // Drop auto once the last frame is under way.
                @(negedge clk);
                auto_a = 1'b0; fetch_a = 1'b0;
                wait_arr_a(1, -1, lat, f, l, rdy1);
            end else begin
                wait_arr_a(0, -1, lat, f, l, rdy1);
            end
            check($sformatf("t3_f%0d_gap", i), 32'(lat), 137);
            score_a($sformatf("t3_f%0d", i));
        end
        idle_watch_a(200, arr, csl, nrdy);
        check("t3_stop_arrivals", 32'(arr), 0);
        check("t3_stop_cs", 32'(csl), 0);

        // 4: fetch while busy is dropped
        d4 = 8'($urandom_range(0, 255));
        fetch_go_a(2'd3, make_word(d4), d4);
        repeat (20) @(negedge clk);
        check("t4_ready_busy", 32'(ready_a), 0);
        fetch_a = 1'b1; chan_a = 2'd1;
        repeat (3) @(negedge clk);
        fetch_a = 1'b0;
        wait_arr_a(23, -1, lat, f, l, rdy1);
        check("t4_latency", 32'(lat), 137);
        score_a("t4");
        idle_watch_a(300, arr, csl, nrdy);
        check("t4_extra_arrivals", 32'(arr), 0);
        check("t4_extra_cs", 32'(csl), 0);
        check("t4_ready_held", 32'(nrdy), 0);
        check("t4_illum_held", 32'(illum_a), 32'(d4));

        // 5: reset in the middle of a frame
        fetch_go_a(2'd2, make_word(8'h3C), 8'h3C);
        void'(exp_q.pop_back());   // this frame is aborted
        guard = 0;
        while (rises_a < 7 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("t5_reach_edge7", 32'(rises_a), 7);
        rst = 1'b1;
        @(negedge clk);
        check("t5_cs", 32'(cs_a), 32'hF);
        check("t5_sclk", 32'(sclk_a), 1);
        check("t5_illum", 32'(illum_a), 0);
        check("t5_arrived", 32'(arrived_a), 0);
        check("t5_ready_in_rst", 32'(ready_a), 0);
        rst = 1'b0;
        idle_watch_a(150, arr, csl, nrdy);
        check("t5_no_arrival", 32'(arr), 0);
        check("t5_no_cs", 32'(csl), 0);
        fetch_go_a(2'd2, make_word(8'b11001110), 8'b11001110);
        wait_arr_a(0, 2, lat, f, l, rdy1);
        check("t5_latency", 32'(lat), 137);
        score_a("t5");

        // 6: narrow build, full 16-bit word, out-of-range channel
        word_b = 16'h770A;
        @(negedge clk);
        fetch_b = 1'b1; chan_b = 1'b0;
        @(posedge clk);
        #1;
        fetch_b = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!arrived_b && cyc < 100);
        check("t6_latency", 32'(arrived_b ? cyc : -1), 35);
        check("t6_illum", 32'(illum_b), 32'h770A);
        check("t6_ichan", 32'(ichan_b), 0);
        @(negedge clk);
        fetch_b = 1'b1; chan_b = 1'b1;   // channel 1 does not exist with NCH=1
        arr = 0; csl = 0; nrdy = 0;
        repeat (40) begin
            @(negedge clk);
            fetch_b = 1'b0;
            if (arrived_b) arr++;
            if (!cs_b[0]) csl++;
            if (!ready_b) nrdy++;
        end
        check("t6_badchan_arrivals", 32'(arr), 0);
        check("t6_badchan_cs", 32'(csl), 0);
        check("t6_badchan_ready", 32'(nrdy), 0);

        check("cs_onehot", 32'(cs_viol), 0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
